quest_pipe: RTL and testbench

Parametrised, pipelined successor to the three-stage commute pass/fail evaluator. Each accepted item carries per-stage scores, thresholds and a random word through NUM_STAGES registered stages. Each stage grades the item against its threshold, applies a random penalty and hands a margin-based bonus to the next stage. The block sits between the scenario generator (upstream valid/ready) and the scoreboard/result logger (downstream valid/ready), and adds optional pass/fail statistics.

---
 rtl/quest_pkg.sv | 17 +
 rtl/quest_stage.sv | 97 +++++++++
 rtl/quest_pipe.sv | 124 ++++++++++++
 tb/tb_quest_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quest_pkg.sv
// Shared constants and types for the quest_pipe grading pipeline.
// Counters are present only when QUEST_PIPE_STATS_EN is defined (see quest_pipe.sv).
package quest_pkg;

  localparam int BONUS_T1   = 8;
  localparam int BONUS_T2   = 16;
  localparam int BONUS_T3   = 24;
  localparam int BONUS_MULT = 4;

  typedef logic [1:0] bonus_t;

  // Width of the 1-based first-failing-stage index (0 means passed).
  function automatic int fail_stage_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/quest_stage.sv
// One grading stage: combinational grade of the incoming item followed by the
// stage register that carries the verdict and the item's data to the next stage.
module quest_stage
  import quest_pkg::*;
#(
  parameter int STAGE_IDX  = 0,
  parameter int NUM_STAGES = 3,
  parameter int SCORE_W    = 7,
  parameter int RAND_W     = 7,
  parameter int FS_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          advance,
  input  logic                          pass_in,
  input  logic [1:0]                    bonus_in,
  input  logic [FS_W-1:0]               fail_stage_in,
  input  logic [NUM_STAGES*SCORE_W-1:0] score_in,
  input  logic [NUM_STAGES*SCORE_W-1:0] thresh_in,
  input  logic [RAND_W-1:0]             random_in,
  output logic                          pass_out,
  output logic [1:0]                    bonus_out,
  output logic [FS_W-1:0]               fail_stage_out,
  output logic [NUM_STAGES*SCORE_W-1:0] score_out,
  output logic [NUM_STAGES*SCORE_W-1:0] thresh_out,
  output logic [RAND_W-1:0]             random_out
);

  localparam int VEC_W = NUM_STAGES * SCORE_W;
  localparam int P_LO  = STAGE_IDX % RAND_W;
  localparam int P_HI  = (STAGE_IDX + NUM_STAGES) % RAND_W;

  logic [SCORE_W-1:0] score_k;
  logic [SCORE_W-1:0] thresh_k;
  logic [SCORE_W:0]   eff_wide;
  logic [SCORE_W-1:0] eff;
  logic [SCORE_W-1:0] margin;
  logic               penalty;
  logic               ok;

  logic               pass_d, pass_q;
  bonus_t             bonus_d, bonus_q;
  logic [FS_W-1:0]    fail_stage_d, fail_stage_q;
  logic [VEC_W-1:0]   score_d, score_q;
  logic [VEC_W-1:0]   thresh_d, thresh_q;
  logic [RAND_W-1:0]  random_d, random_q;

  always_comb begin
    score_k  = score_in[STAGE_IDX*SCORE_W +: SCORE_W];
    thresh_k = thresh_in[STAGE_IDX*SCORE_W +: SCORE_W];
    // One extra bit catches the carry so the effective score can saturate.
    eff_wide = {1'b0, score_k} + ((SCORE_W+1)'(bonus_in) * (SCORE_W+1)'(BONUS_MULT));
    eff      = eff_wide[SCORE_W] ? {SCORE_W{1'b1}} : eff_wide[SCORE_W-1:0];
    penalty  = random_in[P_LO] & random_in[P_HI];
    ok       = (eff >= thresh_k) & ~penalty;
    margin   = eff - thresh_k;

    pass_d       = pass_in & ok;
    fail_stage_d = (pass_in & ~ok) ? FS_W'(STAGE_IDX + 1) : fail_stage_in;
    bonus_d      = 2'd0;
    if (pass_d) begin
      if (32'(margin) >= BONUS_T3)      bonus_d = 2'd3;
      else if (32'(margin) >= BONUS_T2) bonus_d = 2'd2;
      else if (32'(margin) >= BONUS_T1) bonus_d = 2'd1;
    end

    score_d  = score_in;
    thresh_d = thresh_in;
    random_d = random_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q       <= 1'b0;
      bonus_q      <= 2'd0;
      fail_stage_q <= '0;
      score_q      <= '0;
      thresh_q     <= '0;
      random_q     <= '0;
    end else if (advance) begin
      pass_q       <= pass_d;
      bonus_q      <= bonus_d;
      fail_stage_q <= fail_stage_d;
      score_q      <= score_d;
      thresh_q     <= thresh_d;
      random_q     <= random_d;
    end
  end

  assign pass_out       = pass_q;
  assign bonus_out      = bonus_q;
  assign fail_stage_out = fail_stage_q;
  assign score_out      = score_q;
  assign thresh_out     = thresh_q;
  assign random_out     = random_q;

endmodule

// File: rtl/quest_pipe.sv
// Pipelined multi-stage pass/fail evaluator with a whole-pipe stall.
// Optional statistics counters are built when QUEST_PIPE_STATS_EN is defined.
module quest_pipe
  import quest_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SCORE_W    = 7,
  parameter int RAND_W     = 7,
  parameter int CNT_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_STAGES*SCORE_W-1:0]         in_score,
  input  logic [NUM_STAGES*SCORE_W-1:0]         in_thresh,
  input  logic [RAND_W-1:0]                     in_random,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_pass,
  output logic [1:0]                            out_bonus,
  output logic [$clog2(NUM_STAGES+1)-1:0]       out_fail_stage,
  output logic [CNT_W-1:0]                      pass_cnt,
  output logic [CNT_W-1:0]                      fail_cnt
);

  localparam int FS_W  = fail_stage_w(NUM_STAGES);
  localparam int VEC_W = NUM_STAGES * SCORE_W;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and a stalled output holds steady.
  logic                   advance;
  logic [NUM_STAGES-1:0]  valid_d, valid_q;

  logic [NUM_STAGES-1:0]  pass_s;
  logic [1:0]             bonus_s  [NUM_STAGES];
  logic [FS_W-1:0]        fs_s     [NUM_STAGES];
  logic [VEC_W-1:0]       score_s  [NUM_STAGES];
  logic [VEC_W-1:0]       thresh_s [NUM_STAGES];
  logic [RAND_W-1:0]      random_s [NUM_STAGES];

  assign out_valid = valid_q[NUM_STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Bubbles are kept: every slot shifts whenever the pipe advances.
  always_comb begin
    valid_d = valid_q;
    if (advance) valid_d = (valid_q << 1) | NUM_STAGES'(in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      quest_stage #(
        .STAGE_IDX(k), .NUM_STAGES(NUM_STAGES), .SCORE_W(SCORE_W),
        .RAND_W(RAND_W), .FS_W(FS_W)
      ) u_stage (
        .clk(clk), .rst_n(rst_n), .advance(advance),
        .pass_in(1'b1), .bonus_in(2'b00), .fail_stage_in('0),
        .score_in(in_score), .thresh_in(in_thresh), .random_in(in_random),
        .pass_out(pass_s[k]), .bonus_out(bonus_s[k]), .fail_stage_out(fs_s[k]),
        .score_out(score_s[k]), .thresh_out(thresh_s[k]), .random_out(random_s[k])
      );
    end else begin : g_next
      quest_stage #(
        .STAGE_IDX(k), .NUM_STAGES(NUM_STAGES), .SCORE_W(SCORE_W),
        .RAND_W(RAND_W), .FS_W(FS_W)
      ) u_stage (
        .clk(clk), .rst_n(rst_n), .advance(advance),
        .pass_in(pass_s[k-1]), .bonus_in(bonus_s[k-1]), .fail_stage_in(fs_s[k-1]),
        .score_in(score_s[k-1]), .thresh_in(thresh_s[k-1]), .random_in(random_s[k-1]),
        .pass_out(pass_s[k]), .bonus_out(bonus_s[k]), .fail_stage_out(fs_s[k]),
        .score_out(score_s[k]), .thresh_out(thresh_s[k]), .random_out(random_s[k])
      );
    end
  end

  assign out_pass       = pass_s[NUM_STAGES-1];
  assign out_bonus      = bonus_s[NUM_STAGES-1];
  assign out_fail_stage = fs_s[NUM_STAGES-1];

  // The last stage's data copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{score_s[NUM_STAGES-1], thresh_s[NUM_STAGES-1], random_s[NUM_STAGES-1]};

`ifdef QUEST_PIPE_STATS_EN
  logic [CNT_W-1:0] pass_cnt_d, pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_d, fail_cnt_q;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (out_valid & out_ready) begin
      if (out_pass) begin
        if (~&pass_cnt_q) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (~&fail_cnt_q) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_quest_pipe.sv
// Self-checking bench for quest_pipe: vector table, stall/reset/latency
// sequences and a random phase, all checked through an expected-result queue.
module tb_quest_pipe;

  localparam int N   = 3;
  localparam int SW  = 7;
  localparam int RW  = 7;
  localparam int CW  = 16;
  localparam int FSW = 2;

`ifdef QUEST_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*SW-1:0] in_score = '0;
  logic [N*SW-1:0] in_thresh = '0;
  logic [RW-1:0]   in_random = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_pass;
  logic [1:0]      out_bonus;
  logic [FSW-1:0]  out_fail_stage;
  logic [CW-1:0]   pass_cnt;
  logic [CW-1:0]   fail_cnt;

  quest_pipe #(.NUM_STAGES(N), .SCORE_W(SW), .RAND_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_thresh(in_thresh), .in_random(in_random),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pass(out_pass), .out_bonus(out_bonus), .out_fail_stage(out_fail_stage),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];          // {pass, bonus[1:0], fail_stage[1:0]}
  int exp_pass_cnt = 0;
  int exp_fail_cnt = 0;
  int accepted = 0;
  int results_seen = 0;

  typedef struct {
    logic [N*SW-1:0] sc;
    logic [N*SW-1:0] th;
    logic [RW-1:0]   r;
    logic [4:0]      exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [N*SW-1:0] pack3(input int s0, input int s1, input int s2);
    return {SW'(s2), SW'(s1), SW'(s0)};
  endfunction

  // Reference grade of one item through all stages.
  function automatic logic [4:0] model(input logic [N*SW-1:0] sc, input logic [N*SW-1:0] th,
                                       input logic [RW-1:0] r);
    bit p = 1'b1;
    int b = 0;
    int fs = 0;
    for (int k = 0; k < N; k++) begin
      int e;
      int t;
      bit ok;
      e = int'(sc[k*SW +: SW]) + 4 * b;
      if (e > 127) e = 127;
      t = int'(th[k*SW +: SW]);
      ok = (e >= t) && !(r[k % RW] && r[(k + N) % RW]);
      if (p && !ok) fs = k + 1;
      p = p && ok;
      if (p) b = (e - t >= 24) ? 3 : (e - t >= 16) ? 2 : (e - t >= 8) ? 1 : 0;
      else   b = 0;
    end
    return {p, 2'(b), 2'(fs)};
  endfunction

  task automatic set_vec(input int i, input int s0, input int s1, input int s2, input int t,
                         input logic [RW-1:0] r, input logic p, input logic [1:0] b,
                         input logic [1:0] fs);
    vecs[i].sc  = pack3(s0, s1, s2);
    vecs[i].th  = pack3(t, t, t);
    vecs[i].r   = r;
    vecs[i].exp = {p, b, fs};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      results_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("out_pass", out_pass, e[4]);
        check("out_bonus", out_bonus, e[3:2]);
        check("out_fail_stage", out_fail_stage, e[1:0]);
        check("pass_cnt", pass_cnt, STATS ? exp_pass_cnt : 0);
        check("fail_cnt", fail_cnt, STATS ? exp_fail_cnt : 0);
        if (e[4]) begin
          if (exp_pass_cnt < 65535) exp_pass_cnt++;
        end else begin
          if (exp_fail_cnt < 65535) exp_fail_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only just after a rising edge; returns just after the accepting edge.
  task automatic drive_item(input logic [N*SW-1:0] sc, input logic [N*SW-1:0] th,
                            input logic [RW-1:0] r, input logic [4:0] exp);
    int waited = 0;
    in_valid  = 1'b1;
    in_score  = sc;
    in_thresh = th;
    in_random = r;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        accepted++;
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_acc;
    int base_res;
    int stale;
    bit rand_done;

    set_vec(0, 80, 75, 90, 70, 7'd0,        1'b1, 2'd3, 2'd0);
    set_vec(1, 80, 60, 90, 70, 7'd0,        1'b0, 2'd0, 2'd2);
    set_vec(2, 90, 90, 90, 70, 7'b0001001,  1'b0, 2'd0, 2'd1);
    set_vec(3, 127, 127, 127, 100, 7'd0,    1'b1, 2'd3, 2'd0);
    set_vec(4, 70, 70, 70, 70, 7'd0,        1'b1, 2'd0, 2'd0);
    set_vec(5, 90, 90, 90, 70, 7'b0100100,  1'b0, 2'd0, 2'd3);
    set_vec(6, 86, 70, 83, 70, 7'd0,        1'b1, 2'd2, 2'd0);
    set_vec(7, 80, 10, 10, 70, 7'd0,        1'b0, 2'd0, 2'd2);

    // Power-on reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_fail_stage", out_fail_stage, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    out_ready = 1'b1;

    // Latency on an empty pipe: result visible after NUM_STAGES edges
    drive_item(vecs[0].sc, vecs[0].th, vecs[0].r, vecs[0].exp);
    @(negedge clk); check("latency_edge1", out_valid, 0);
    @(negedge clk); check("latency_edge2", out_valid, 0);
    @(negedge clk); check("latency_edge3", out_valid, 1);
    sync();

    // Vector table, back-to-back
    for (int i = 0; i < 8; i++) drive_item(vecs[i].sc, vecs[i].th, vecs[i].r, vecs[i].exp);
    wait_drain();

    // Reset while two items are in flight: they must vanish
    in_valid  = 1'b1;
    in_score  = vecs[0].sc;
    in_thresh = vecs[0].th;
    in_random = vecs[0].r;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_pass", out_pass, 0);
    check("midrst_out_fail_stage", out_fail_stage, 0);
    check("midrst_pass_cnt", pass_cnt, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_stale_results", stale, 0);
    sync();

    // Stall: out_ready low, offer four items
    out_ready = 1'b0;
    base_acc = accepted;
    base_res = results_seen;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_item(vecs[i].sc, vecs[i].th, vecs[i].r, vecs[i].exp);
      end
    join_none
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("stall_accepted", accepted - base_acc, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    check("stall_hold_valid", out_valid, 1);
    check("stall_hold_pass", out_pass, vecs[0].exp[4]);
    check("stall_hold_bonus", out_bonus, vecs[0].exp[3:2]);
    check("stall_hold_fs", out_fail_stage, vecs[0].exp[1:0]);
    sync();
    out_ready = 1'b1;
    wait_drain();
    check("stall_results", results_seen - base_res, 4);
    check("stall_all_accepted", accepted - base_acc, 4);

    // Random traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [N*SW-1:0] sc;
          logic [N*SW-1:0] th;
          logic [RW-1:0]   r;
          for (int k = 0; k < N; k++) begin
            sc[k*SW +: SW] = SW'($urandom_range(30, 127));
            th[k*SW +: SW] = SW'($urandom_range(40, 110));
          end
          r = ($urandom_range(0, 1) == 1) ? RW'($urandom_range(0, 127)) : '0;
          drive_item(sc, th, r, model(sc, th, r));
          repeat ($urandom_range(0, 1)) sync();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          sync();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    repeat (2) sync();
    check("total_results", results_seen, accepted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
